// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 800x600 timing defaults and test-pattern bar colours
package vga_pkg;

    localparam int HOR_PIXELS     = 800;
    localparam int HOR_TOTAL      = 1056;
    localparam int HOR_SYNC_START = 840;
    localparam int HOR_SYNC_WIDTH = 128;
    localparam int HOR_FP         = HOR_SYNC_START - HOR_PIXELS;

    localparam int VER_PIXELS     = 600;
    localparam int VER_TOTAL      = 628;
    localparam int VER_SYNC_START = 601;
    localparam int VER_SYNC_WIDTH = 4;
    localparam int VER_FP         = VER_SYNC_START - VER_PIXELS;

    localparam int CNT_W = 11;

    // Left-to-right bar colours, indexed by hcount[9:7]
    localparam logic [11:0] BAR_COLORS [0:7] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel stream bundle shared by the draw pipeline
interface vga_if;

    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport out (
        output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
    );

    modport in (
        input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
    );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter with blank/sync decode
module vga_axis_counter import vga_pkg::*; #(
    parameter int   ACTIVE   = HOR_PIXELS,
    parameter int   FP       = HOR_FP,
    parameter int   SYNC     = HOR_SYNC_WIDTH,
    parameter int   TOTAL    = HOR_TOTAL,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count_q,
    output logic [CNT_W-1:0] count_d,
    output logic             blnk_q,
    output logic             blnk_d,
    output logic             sync_q,
    output logic             carry
);

    // 12-bit bounds so a sync end of exactly 2048 does not wrap
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   BLNK_START = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0]   SYNC_START = (CNT_W+1)'(ACTIVE + FP);
    localparam logic [CNT_W:0]   SYNC_END   = (CNT_W+1)'(ACTIVE + FP + SYNC);

    if (TOTAL > 2048 || TOTAL < 1) begin : g_bad_total
        $error("vga_axis_counter: TOTAL=%0d outside 1..2048", TOTAL);
    end
    if (ACTIVE + FP + SYNC > TOTAL) begin : g_bad_sum
        $error("vga_axis_counter: ACTIVE+FP+SYNC=%0d exceeds TOTAL=%0d",
               ACTIVE + FP + SYNC, TOTAL);
    end

    logic sync_d;

    // Next count: advance on enable, wrap at the last position and flag carry
    always_comb begin
        count_d = count_q;
        carry   = 1'b0;
        if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                carry   = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Decode blank/sync from the next count so they land with that count
    always_comb begin
        blnk_d = ({1'b0, count_d} >= BLNK_START);
        sync_d = ~SYNC_POL;
        if ({1'b0, count_d} >= SYNC_START && {1'b0, count_d} < SYNC_END) begin
            sync_d = SYNC_POL;
        end
    end

    // Register count and its decoded flags together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing source; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_gen import vga_pkg::*; #(
    parameter int   H_ACTIVE = HOR_PIXELS,
    parameter int   H_FP     = HOR_FP,
    parameter int   H_SYNC   = HOR_SYNC_WIDTH,
    parameter int   H_TOTAL  = HOR_TOTAL,
    parameter int   V_ACTIVE = VER_PIXELS,
    parameter int   V_FP     = VER_FP,
    parameter int   V_SYNC   = VER_SYNC_WIDTH,
    parameter int   V_TOTAL  = VER_TOTAL,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  pix_en,
    vga_if.out    out,
    output logic  frame_start
);

    logic [CNT_W-1:0] h_count_q, h_next;
    logic [CNT_W-1:0] v_count_q, v_next;
    logic             h_blnk_q, h_blnk_d, h_sync_q, h_carry;
    logic             v_blnk_q, v_blnk_d, v_sync_q, v_carry;
    logic             v_en;
    logic             frame_start_d, frame_start_q;
    logic             unused_next;

    assign v_en = pix_en & h_carry;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .TOTAL(H_TOTAL), .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk(clk), .rst(rst), .en(pix_en),
        .count_q(h_count_q), .count_d(h_next),
        .blnk_q(h_blnk_q), .blnk_d(h_blnk_d),
        .sync_q(h_sync_q), .carry(h_carry)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .TOTAL(V_TOTAL), .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk(clk), .rst(rst), .en(v_en),
        .count_q(v_count_q), .count_d(v_next),
        .blnk_q(v_blnk_q), .blnk_d(v_blnk_d),
        .sync_q(v_sync_q), .carry(v_carry)
    );

    // Vertical carry only fires on the (last,last) -> (0,0) step, so it is the frame marker
    always_comb begin
        frame_start_d = v_carry;
    end

    // Frame strobe register; reset clears it so reset never looks like a frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb_d, rgb_q;

    // Pick the bar colour from the next position, black when blanked
    always_comb begin
        rgb_d = 12'h000;
        if (!h_blnk_d && !v_blnk_d) begin
            rgb_d = BAR_COLORS[h_next[9:7]];
        end
    end

    // Register colour alongside the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign out.rgb = rgb_q;
`else
    assign out.rgb = 12'h000;
`endif

    // Next-state values are only consumed by the optional pattern logic
    assign unused_next = ^{h_next, h_blnk_d, v_next, v_blnk_d};

    assign out.hcount  = h_count_q;
    assign out.vcount  = v_count_q;
    assign out.hblnk   = h_blnk_q;
    assign out.vblnk   = v_blnk_q;
    assign out.hsync   = h_sync_q;
    assign out.vsync   = v_sync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (default and small timings)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic pix_en_a, pix_en_b;
    logic fs_a, fs_b;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    vga_if vga_a ();
    vga_if vga_b ();

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .out(vga_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(2), .H_TOTAL(16),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_TOTAL(8),
        .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(pix_en_b), .out(vga_b), .frame_start(fs_b)
    );

    function automatic logic [11:0] bar(input int h);
        case ((h / 128) % 8)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] exp_rgb(input int h, input int v, input int ha, input int va);
`ifdef VGA_TEST_PATTERN_EN
        if (h < ha && v < va) return bar(h);
        return 12'h000;
`else
        if (h < 0 || v < 0 || ha < 0 || va < 0) return 12'hFFF;
        return 12'h000;
`endif
    endfunction

    // {hcount, vcount, hblnk, vblnk, hsync, vsync, rgb, frame_start}
    function automatic logic [38:0] exp_a(input int h, input int v, input logic fs);
        logic hb, vb, hs, vs;
        hb = (h >= 800);
        vb = (v >= 600);
        hs = (h >= 840 && h < 968);
        vs = (v >= 601 && v < 605);
        return {11'(h), 11'(v), hb, vb, hs, vs, exp_rgb(h, v, 800, 600), fs};
    endfunction

    function automatic logic [38:0] exp_b(input int h, input int v, input logic fs);
        logic hb, vb, hs, vs;
        hb = (h >= 10);
        vb = (v >= 4);
        hs = !(h >= 12 && h < 14);
        vs = !(v == 5);
        return {11'(h), 11'(v), hb, vb, hs, vs, exp_rgb(h, v, 10, 4), fs};
    endfunction

    function automatic logic [38:0] obs_a();
        return {vga_a.hcount, vga_a.vcount, vga_a.hblnk, vga_a.vblnk,
                vga_a.hsync, vga_a.vsync, vga_a.rgb, fs_a};
    endfunction

    function automatic logic [38:0] obs_b();
        return {vga_b.hcount, vga_b.vcount, vga_b.hblnk, vga_b.vblnk,
                vga_b.hsync, vga_b.vsync, vga_b.rgb, fs_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        pix_en_a = 1'b1; pix_en_b = 1'b1;
        repeat (3) step();
        vectors++;
        if (obs_a() !== exp_a(0, 0, 1'b0)) begin
            $display("FAIL reset_a got %h want %h", obs_a(), exp_a(0, 0, 1'b0));
            errors++;
        end
        vectors++;
        if (obs_b() !== exp_b(0, 0, 1'b0)) begin
            $display("FAIL reset_b got %h want %h", obs_b(), exp_b(0, 0, 1'b0));
            errors++;
        end
    endtask

    task automatic test_line();
        rst_a = 1'b1;
        for (int i = 1; i <= 1056; i++) begin
            step();
            vectors++;
            if (obs_a() !== exp_a(i % 1056, i / 1056, 1'b0)) begin
                $display("FAIL line i=%0d got %h want %h", i, obs_a(), exp_a(i % 1056, i / 1056, 1'b0));
                errors++;
            end
        end
    endtask

    task automatic test_hold();
        repeat (20) step();
        pix_en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (obs_a() !== exp_a(20, 1, 1'b0)) begin
                $display("FAIL hold i=%0d got %h want %h", i, obs_a(), exp_a(20, 1, 1'b0));
                errors++;
            end
        end
        pix_en_a = 1'b1;
        step();
        vectors++;
        if (obs_a() !== exp_a(21, 1, 1'b0)) begin
            $display("FAIL hold_resume got %h want %h", obs_a(), exp_a(21, 1, 1'b0));
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        repeat (479) step();
        vectors++;
        if (obs_a() !== exp_a(500, 1, 1'b0)) begin
            $display("FAIL pre_reset got %h want %h", obs_a(), exp_a(500, 1, 1'b0));
            errors++;
        end
        #2 rst_a = 1'b0;
        #1;
        vectors++;
        if (obs_a() !== exp_a(0, 0, 1'b0)) begin
            $display("FAIL async_reset got %h want %h", obs_a(), exp_a(0, 0, 1'b0));
            errors++;
        end
        step();
        vectors++;
        if (obs_a() !== exp_a(0, 0, 1'b0)) begin
            $display("FAIL reset_held got %h want %h", obs_a(), exp_a(0, 0, 1'b0));
            errors++;
        end
        rst_a = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            vectors++;
            if (obs_a() !== exp_a(k, 0, 1'b0)) begin
                $display("FAIL resume k=%0d got %h want %h", k, obs_a(), exp_a(k, 0, 1'b0));
                errors++;
            end
        end
    endtask

    task automatic test_small_frame();
        int pulses;
        pulses = 0;
        rst_b = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (fs_b === 1'b1) pulses++;
            vectors++;
            if (obs_b() !== exp_b(i % 16, (i / 16) % 8, (i % 128) == 0)) begin
                $display("FAIL small_frame i=%0d got %h want %h", i, obs_b(),
                         exp_b(i % 16, (i / 16) % 8, (i % 128) == 0));
                errors++;
            end
        end
        vectors++;
        if (pulses != 2) begin
            $display("FAIL small_frame_pulses got %0d want 2", pulses);
            errors++;
        end
    endtask

    task automatic test_pix_en_toggle();
        int n, pulses;
        logic fs_exp;
        n = 0;
        pulses = 0;
        for (int j = 0; j < 256; j++) begin
            pix_en_b = (j % 2) == 1;
            step();
            if (pix_en_b) begin
                n++;
                fs_exp = (n % 128) == 0;
            end else begin
                fs_exp = 1'b0;
            end
            if (fs_b === 1'b1) pulses++;
            vectors++;
            if (obs_b() !== exp_b(n % 16, (n / 16) % 8, fs_exp)) begin
                $display("FAIL toggle j=%0d got %h want %h", j, obs_b(), exp_b(n % 16, (n / 16) % 8, fs_exp));
                errors++;
            end
        end
        vectors++;
        if (pulses != 1) begin
            $display("FAIL toggle_pulses got %0d want 1", pulses);
            errors++;
        end
        pix_en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line();
        test_hold();
        test_reset_mid();
        test_small_frame();
        test_pix_en_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Source end of the vga_if pixel stream: generates hcount/vcount, hsync/vsync and hblnk/vblnk for every downstream draw_* stage. Sits at the head of the top_vga pipeline, driven by the pixel clock domain, and feeds the first drawing stage through vga_if.out. Replaces ad-hoc counter logic with one parameterised, pixel-enable-aware generator.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync width (pixels)
H_TOTAL, 1056, total pixels per line
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_TOTAL, 628, total lines per frame
SYNC_POL, 1'b1, active level of hsync/vsync

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-low
pix_en  in  1  counter advance enable, one pixel per asserted cycle
out  vga_if.out  -  vcount/hcount [10:0], vsync, hsync, vblnk, hblnk, rgb [11:0]
frame_start  out  1  one-cycle strobe when counters enter (0,0)

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-to-clk release via flop clear): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=vsync=~SYNC_POL, rgb=0, frame_start=0.
- Counters: on clk edge with pix_en=1: hcount<=hcount+1; at hcount==H_TOTAL-1 -> hcount<=0 and vcount<=vcount+1; at vcount==V_TOTAL-1 and line end -> vcount<=0. pix_en=0: all outputs hold (frame_start forced 0).
- All outputs registered; sync/blank are decoded from the next-state counter values so they are cycle-aligned with the hcount/vcount they describe (zero skew between fields).
- hblnk = next_h >= H_ACTIVE; vblnk = next_v >= V_ACTIVE.
- hsync = SYNC_POL when H_ACTIVE+H_FP <= next_h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL. vsync likewise on next_v with V_* params (whole lines).
- frame_start = 1 for exactly one clk when counters transition from (H_TOTAL-1, V_TOTAL-1) to (0,0); never asserted by reset itself.
- Widths: counters 11 bit; params must satisfy H_TOTAL, V_TOTAL <= 2048 and ACTIVE+FP+SYNC <= TOTAL; violation -> $error at elaboration.
- Reset mid-frame: immediate return to reset values; counting resumes from (0,0) with no frame_start pulse for that frame start.
- rgb: 12'h000 always (without optional feature).

Optional Feature:
VGA_TEST_PATTERN_EN: when defined, rgb during active area (hblnk=vblnk=0) is an 8-bar colour pattern selected by next_h[9:7] (white, yellow, cyan, green, magenta, red, blue, black: 12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000), 12'h000 when blanked; registered with same alignment as hcount. Undefined: rgb constant 12'h000, no pattern logic synthesised.

Decomposition:
- vga_pkg: 800x600 timing localparams (HOR_PIXELS, HOR_TOTAL, HOR_SYNC_START, HOR_SYNC_WIDTH, VER_* equivalents), used as parameter defaults; bar-colour constant array.
- One sub-module: vga_axis_counter (one instance per axis): counter with wrap, enable, carry-out, and registered blank/sync decode; vertical instance enabled by pix_en AND horizontal carry.

Test Plan:
- Reset then 1056 cycles pix_en=1 -> hcount 0..1055 then 0, vcount 0->1; hblnk rises with hcount=800, hsync active hcount 840..967 only.
- Run full frame 1056*628 = 663168 cycles -> exactly one frame_start, aligned with (0,0); vblnk high vcount 600..627; vsync active vcount 601..604.
- pix_en toggled 1/0 alternately -> each field advances only on enabled cycles; frame after 1326336 clocks; no frame_start while held.
- rst low at hcount=500,vcount=300 for 1 cycle, asynchronously mid-cycle -> outputs at reset values before next clk edge; resume from (0,0), no frame_start pulse.
- SYNC_POL=0, small timing (H 10/2/2/16, V 4/1/1/8) -> sync low-active at hcount 12..13, vcount 5; frame_start every 128 enabled cycles.
- With VGA_TEST_PATTERN_EN: hcount=0 -> rgb 12'hFFF, hcount=128 -> 12'hFF0, hcount=800 -> 12'h000; without macro rgb 0 throughout.
